// File: rtl/regfile_scoreboard.sv
// Parametrised register file with write bypass, zero register,
// busy scoreboard and a reset-driven clear sequencer.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_set_addr,
  output logic              ready
);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] init_cnt, init_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_ok, set_ok;

  function automatic logic legal(input logic [ADDR_W-1:0] a);
    legal = (32'(a) < 32'(DEPTH)) &&
            !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Port view: zero when not ready or illegal, else stored or bypassed.
  function automatic logic [DATA_W:0] read_port(
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] d;
    logic              b;
    d = '0;
    b = 1'b0;
    if (ready && legal(a)) begin
      d = mem[a];
      b = busy[a];
      if ((BYPASS != 0) && wr_ok && (wr_addr == a)) begin
        d = wr_data;
        b = set_ok && (busy_set_addr == a);
      end
    end
    return {b, d};
  endfunction

  assign wr_ok  = ready && wr_en && legal(wr_addr);
  assign set_ok = ready && busy_set && legal(busy_set_addr);

  assign {busy_a, rd_data_a} = read_port(rd_addr_a);
  assign {busy_b, rd_data_b} = read_port(rd_addr_b);

  // State register and clear-sequencer pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nx;
      init_cnt <= init_nx;
    end
  end

  // Sweep every entry once, then hand over to normal operation.
  always_comb begin
    state_nx = state;
    init_nx  = init_cnt;
    ready    = (state == RUN);
    if (state == INIT) begin
      init_nx = init_cnt + 1'b1;
      if (init_cnt == ADDR_W'(DEPTH - 1)) begin
        state_nx = RUN;
        init_nx  = '0;
      end
    end
  end

  // Storage: zero-fill while sweeping, writeback afterwards.
  always_ff @(posedge clk) begin
    if (state == INIT)
      mem[init_cnt] <= '0;
    else if (wr_ok)
      mem[wr_addr] <= wr_data;
  end

  // Scoreboard: writeback clears, issue sets; issue wins on collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (wr_ok)
        busy[wr_addr] <= 1'b0;
      if (set_ok)
        busy[busy_set_addr] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: default file plus a 20-entry,
// no-bypass variant sharing the same stimulus.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        busy_a, busy_b;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy_set;
  logic [4:0]  busy_set_addr;
  logic        ready;

  logic [31:0] alt_data_a, alt_data_b;
  logic        alt_busy_a, alt_busy_b;
  logic        alt_ready;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  regfile_scoreboard u_dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .busy_a(busy_a), .busy_b(busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy_set(busy_set), .busy_set_addr(busy_set_addr),
    .ready(ready)
  );

  regfile_scoreboard #(
    .DEPTH(20), .BYPASS(0)
  ) u_alt (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(alt_data_a), .rd_data_b(alt_data_b),
    .busy_a(alt_busy_a), .busy_b(alt_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy_set(busy_set), .busy_set_addr(busy_set_addr),
    .ready(alt_ready)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = 1'b0;
    busy_set = 1'b0;
  endtask

  int n;
  int n_alt;

  initial begin
    rst = 1'b1;
    rd_addr_a = '0; rd_addr_b = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    busy_set = 1'b0; busy_set_addr = '0;

    repeat (2) tick();
    rd_addr_a = 5'd4;
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_data", rd_data_a, 0);
    chk("rst_busy", busy_a, 0);

    // Release reset with writes and issues pulsed during INIT.
    rst = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hAAAA;
    busy_set = 1'b1; busy_set_addr = 5'd8;
    n = 0;
    n_alt = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
      if (alt_ready && n_alt == 0) n_alt = n;
      if (n == 10) idle();
    end
    chk("init_edges", n, 32);
    chk("alt_init_edges", n_alt, 20);

    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i);
      rd_addr_b = 5'(31 - i);
      #1;
      chk($sformatf("clr_a%0d", i), rd_data_a, 0);
      chk($sformatf("clr_b%0d", i), rd_data_b, 0);
    end
    rd_addr_a = 5'd8;
    #1;
    chk("init_no_busy", busy_a, 0);

    // Write reg5 with same-cycle read.
    tick();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    rd_addr_a = 5'd5;
    #1;
    chk("byp_data", rd_data_a, 32'hDEADBEEF);
    chk("nobyp_data", alt_data_a, 0);
    tick();
    wr_addr = 5'd9; wr_data = 32'h6;
    tick();
    idle();
    rd_addr_a = 5'd5; rd_addr_b = 5'd9;
    #1;
    chk("rd_a5", rd_data_a, 32'hDEADBEEF);
    chk("rd_b9", rd_data_b, 32'h6);
    chk("alt_rd_a5", alt_data_a, 32'hDEADBEEF);
    rd_addr_b = 5'd5;
    #1;
    chk("same_addr", rd_data_b, 32'hDEADBEEF);

    // Hardwired zero register.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    busy_set = 1'b1; busy_set_addr = 5'd0;
    rd_addr_a = 5'd0;
    #1;
    chk("r0_comb", rd_data_a, 0);
    tick();
    idle();
    #1;
    chk("r0_data", rd_data_a, 0);
    chk("r0_busy", busy_a, 0);

    // Scoreboard on reg12.
    busy_set = 1'b1; busy_set_addr = 5'd12;
    rd_addr_a = 5'd12;
    #1;
    chk("busy_pre", busy_a, 0);
    tick();
    idle();
    #1;
    chk("busy_set", busy_a, 1);
    chk("alt_busy_set", alt_busy_a, 1);
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h55;
    #1;
    chk("wb_busy_byp", busy_a, 0);
    chk("wb_data_byp", rd_data_a, 32'h55);
    chk("wb_busy_nobyp", alt_busy_a, 1);
    chk("wb_data_nobyp", alt_data_a, 0);
    tick();
    idle();
    #1;
    chk("wb_busy", busy_a, 0);
    chk("wb_data", rd_data_a, 32'h55);
    chk("alt_wb_busy", alt_busy_a, 0);
    wr_en = 1'b1; wr_data = 32'h77;
    busy_set = 1'b1; busy_set_addr = 5'd12;
    #1;
    chk("coll_busy_comb", busy_a, 1);
    chk("coll_data_comb", rd_data_a, 32'h77);
    tick();
    idle();
    #1;
    chk("coll_busy", busy_a, 1);
    chk("coll_data", rd_data_a, 32'h77);
    chk("alt_coll_busy", alt_busy_a, 1);

    // Out-of-range address on the 20-entry file.
    wr_en = 1'b1; wr_addr = 5'd25; wr_data = 32'h99;
    rd_addr_b = 5'd25;
    #1;
    chk("oob_comb", alt_data_b, 0);
    tick();
    idle();
    #1;
    chk("oob_alt", alt_data_b, 0);
    chk("oob_main", rd_data_b, 32'h99);

    // Mid-run reset.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h1234;
    tick();
    idle();
    rd_addr_b = 5'd3;
    #1;
    chk("r3_pre", rd_data_b, 32'h1234);
    rst = 1'b1;
    #1;
    chk("mid_ready", ready, 0);
    chk("mid_busy", busy_a, 0);
    chk("mid_data", rd_data_b, 0);
    tick();
    rst = 1'b0;
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
    chk("reinit_edges", n, 32);
    chk("r3_post", rd_data_b, 0);
    chk("busy_post", busy_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the CPU register file: N-entry, DATA_W-bit, two combinational read ports and one write port.
- Adds write-to-read bypass, an optional hardwired-zero register 0, and a per-register busy scoreboard for hazard detection.
- Adds a reset-driven clear sequencer, so no initial-block preload is required.
- Sits between decode (reads, busy checks, busy_set on issue) and writeback (wr_en).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width
DEPTH, 32, number of registers (2 to 2**ADDR_W)
ZERO_REG, 1, 1 = register 0 always reads 0, is never written, never busy
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous active-high reset
rd_addr_a  in  ADDR_W  read port A address
rd_addr_b  in  ADDR_W  read port B address
rd_data_a  out  DATA_W  read port A data (combinational)
rd_data_b  out  DATA_W  read port B data (combinational)
busy_a  out  1  register at rd_addr_a has a pending write
busy_b  out  1  register at rd_addr_b has a pending write
wr_en  in  1  writeback strobe
wr_addr  in  ADDR_W  writeback address
wr_data  in  DATA_W  writeback data
busy_set  in  1  mark busy_set_addr pending (instruction issue)
busy_set_addr  in  ADDR_W  register to mark
ready  out  1  initialisation complete; file usable

Behaviour:
- States: INIT, RUN.
- Reset (rst=1, asynchronous):
  - state=INIT, init_cnt=0, all busy bits 0, ready=0.
  - rd_data_a/b=0 and busy_a/b=0 while ready=0.
- INIT:
  - Each rising edge writes 0 to mem[init_cnt], then init_cnt+1.
  - The edge that writes entry DEPTH-1 moves to RUN; ready=1 from that edge.
  - So ready rises exactly DEPTH edges after rst deasserts.
  - wr_en and busy_set are ignored in INIT.
- RUN, write:
  - On a rising edge with wr_en=1 and a legal address, mem[wr_addr]<=wr_data and busy[wr_addr]<=0.
  - Illegal address: wr_addr>=DEPTH, or wr_addr=0 with ZERO_REG=1. Such writes are dropped.
- RUN, read (combinational):
  - rd_data_x = mem[rd_addr_x].
  - Returns 0 if rd_addr_x>=DEPTH, or rd_addr_x=0 with ZERO_REG=1.
- Bypass (BYPASS=1):
  - If wr_en=1, the write is legal, and wr_addr==rd_addr_x, then rd_data_x=wr_data in the same cycle.
  - In the same case busy_x=0, unless the same-cycle busy_set targets that register.
  - BYPASS=0: the read returns the old value until the next cycle.
- Scoreboard:
  - busy_set=1 at an edge sets busy[busy_set_addr]. Ignored if the address is illegal (same rule as writes).
  - Same edge, same address for busy_set and wr_en: set wins. A new producer was issued, so the bit ends at 1 while the data is written.
  - Different addresses: both actions apply.
  - busy_x = busy[rd_addr_x], combinational.
- Both read ports may use the same address and return identical results.
- rst asserted mid-RUN:
  - Immediate: ready=0, scoreboard cleared, outputs 0.
  - Full re-initialisation follows; stored contents are lost.
- Write-only latency: 1 edge. Read latency: 0 (combinational). No back-pressure.

Test Plan:
- Reset, then DEPTH=32: count edges after rst falls -> ready=1 after exactly 32 edges. Every register reads 0. wr_en pulsed during INIT -> no effect.
- RUN: write reg5=0xDEADBEEF, reg9=0x00000006; read A=5, B=9 next cycle -> 0xDEADBEEF, 0x00000006. Same cycle as the reg5 write, rd_addr_a=5 -> 0xDEADBEEF with BYPASS=1; previous value (0) with BYPASS=0.
- ZERO_REG=1: write reg0=0xFFFFFFFF -> reg0 reads 0. busy_set on reg0 -> busy stays 0.
- busy_set reg12 -> busy_a=1 at rd_addr_a=12 next cycle. Later wr_en reg12=0x55 -> busy_a=0 (same cycle with bypass) and data=0x55. Simultaneous busy_set and wr_en on reg12 -> data written, busy remains 1.
- DEPTH=20, ADDR_W=5: write addr 25 -> dropped. Read addr 25 -> 0.
- Mid-RUN rst pulse after writing reg3=0x1234 -> ready falls immediately, busy cleared. After 32 edges reg3 reads 0.
